cpu_mem_responder: RTL and testbench

- Memory-side responder for the CPU data bus. Accepts the CPU's read/write requests: address, size, and write data.
- Serialises each request into 1-byte accesses on a byte-wide synchronous RAM port.
- Assembles read bytes little-endian and returns them on the CPU data input.
- Holds the CPU's enable input low while an access is in flight, which stalls the CPU.

---
 rtl/cpu_mem_responder_pkg.sv | 31 +++
 rtl/cpu_mem_responder_if.sv | 23 ++
 rtl/cpu_mem_responder.sv | 147 ++++++++++++++
 tb/tb_cpu_mem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_responder_pkg.sv
// Shared types for the CPU memory responder: request size encoding,
// responder FSM states and the size-to-byte-count helper.
package pkg_cpu;

   typedef enum logic [1:0] {
      ReqDataSz8  = 2'd0,
      ReqDataSz16 = 2'd1,
      ReqDataSz32 = 2'd2,
      ReqDataSz48 = 2'd3
   } ReqDataSz;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } RespState;

   localparam int resp_max_bytes = 6;

   function automatic logic [2:0] req_size_to_nbytes(input ReqDataSz sz);
      logic [2:0] n;
      case (sz)
         ReqDataSz8:  n = 3'd1;
         ReqDataSz16: n = 3'd2;
         ReqDataSz32: n = 3'd4;
         default:     n = 3'd6;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// CPU-side request/response bundle between the CPU data port and the
// memory responder.
interface cpu_mem_responder_if #(
   parameter int BUS_W = 48
);
   logic             req_rd;
   logic             req_wr;
   logic [1:0]       req_size;
   logic [31:0]      req_addr;
   logic [BUS_W-1:0] req_wdata;
   logic             cpu_enable;
   logic [BUS_W-1:0] data_out;

   modport master (
      output req_rd, req_wr, req_size, req_addr, req_wdata,
      input  cpu_enable, data_out
   );

   modport slave (
      input  req_rd, req_wr, req_size, req_addr, req_wdata,
      output cpu_enable, data_out
   );
endinterface

// File: rtl/cpu_mem_responder.sv
// Serialises CPU read/write requests into byte accesses on a byte-wide RAM,
// assembling read bytes little-endian and stalling the CPU while busy.
module cpu_mem_responder
   import pkg_cpu::*;
#(
   parameter int ADDR_W = 16,
   parameter int BUS_W  = 48
) (
   input  logic                clk,
   input  logic                rst,
   cpu_mem_responder_if.slave  cpu,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic [7:0]          mem_wdata,
   input  logic [7:0]          mem_rdata,
   output logic                err_conflict
);

   RespState state, state_nxt;

   logic              req_vld;
   logic              req_take;
   logic [ADDR_W-1:0] addr_p0;
   logic [2:0]        nbytes_p0;
   logic [BUS_W-1:0]  wdata_p0;
   logic              op_rd_p0;
   logic [2:0]        idx;
   logic [2:0]        idx_inc;
   logic              last_issue;
   logic              vld_p1;
   logic [2:0]        cap;
   logic [BUS_W-1:0]  asm_p1;
   logic [BUS_W-1:0]  asm_nxt;
   logic              unused_ok;

   assign req_vld    = cpu.req_rd | cpu.req_wr;
   assign req_take   = (state == ST_IDLE) && req_vld;
   assign idx_inc    = idx + 3'd1;
   assign last_issue = (idx == (nbytes_p0 - 3'd1));
   assign unused_ok  = ^{cpu.req_addr[31:ADDR_W], wdata_p0[7:0]};

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // FSM: next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (req_vld) state_nxt = ST_ISSUE;
         ST_ISSUE: if (last_issue) state_nxt = op_rd_p0 ? ST_DRAIN : ST_IDLE;
         ST_DRAIN: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // FSM: outputs (CPU runs only while the responder is idle)
   always_comb begin
      cpu.cpu_enable = (state == ST_IDLE);
   end

   // Request latch, stage p0; held for the whole access
   always_ff @(posedge clk) begin
      if (req_take) begin
         addr_p0   <= cpu.req_addr[ADDR_W-1:0];
         nbytes_p0 <= req_size_to_nbytes(ReqDataSz'(cpu.req_size));
         wdata_p0  <= cpu.req_wdata;
         op_rd_p0  <= cpu.req_rd;
      end
   end

   // RAM strobes: byte 0 is issued straight from the request, later bytes
   // from the latched copy, so byte k appears in cycle C(k+1).
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr  <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_wdata <= '0;
         idx       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_vld) begin
                  mem_addr  <= cpu.req_addr[ADDR_W-1:0];
                  mem_rd    <= cpu.req_rd;
                  mem_wr    <= ~cpu.req_rd;
                  mem_wdata <= cpu.req_wdata[7:0];
                  idx       <= '0;
               end
            end
            ST_ISSUE: begin
               if (last_issue) begin
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
               end else begin
                  idx       <= idx_inc;
                  mem_addr  <= addr_p0 + ADDR_W'(idx_inc);
                  mem_wdata <= wdata_p0[{idx_inc, 3'b000} +: 8];
               end
            end
            default: begin
               mem_rd <= 1'b0;
               mem_wr <= 1'b0;
            end
         endcase
      end
   end

   // Capture stage p1: RAM data arrives one cycle after mem_rd, so the
   // capture pointer trails the issue counter by one byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         cap    <= '0;
      end else begin
         vld_p1 <= mem_rd;
         if (req_take)    cap <= '0;
         else if (vld_p1) cap <= cap + 3'd1;
      end
   end

   always_comb begin
      asm_nxt = asm_p1;
      if (vld_p1) asm_nxt[{cap, 3'b000} +: 8] = mem_rdata;
   end

   always_ff @(posedge clk) begin
      if (req_take) asm_p1 <= '0;
      else          asm_p1 <= asm_nxt;
   end

   // Result publish: data_out moves only when a read drains
   always_ff @(posedge clk) begin
      if (rst)                    cpu.data_out <= '0;
      else if (state == ST_DRAIN) cpu.data_out <= asm_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst)                                   err_conflict <= 1'b0;
      else if (req_take && cpu.req_rd && cpu.req_wr) err_conflict <= 1'b1;
   end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder with a byte RAM model and
// hand-computed expected values.
module tb_cpu_mem_responder;

   localparam int ADDR_W = 16;
   localparam int BUS_W  = 48;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_wr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              err_conflict;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cpu_mem_responder_if #(.BUS_W(BUS_W)) cpu_bus ();

   cpu_mem_responder #(.ADDR_W(ADDR_W), .BUS_W(BUS_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .cpu          (cpu_bus.slave),
      .mem_addr     (mem_addr),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .err_conflict (err_conflict)
   );

   logic [7:0]  ram [0:65535];
   logic        bd_we   = 1'b0;
   logic [15:0] bd_addr = '0;
   logic [7:0]  bd_data = '0;
   int          rd_strobes = 0;
   int          wr_strobes = 0;

   always @(posedge clk) begin
      if (bd_we)       ram[bd_addr]  <= bd_data;
      else if (mem_wr) ram[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= ram[mem_addr];
      if (mem_rd) rd_strobes <= rd_strobes + 1;
      if (mem_wr) wr_strobes <= wr_strobes + 1;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   // Presents a request during C0; returns at the negedge inside C1.
   task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [47:0] wd);
      @(negedge clk);
      cpu_bus.req_rd = rd; cpu_bus.req_wr = wr; cpu_bus.req_size = sz;
      cpu_bus.req_addr = a; cpu_bus.req_wdata = wd;
      @(negedge clk);
      cpu_bus.req_rd = 1'b0; cpu_bus.req_wr = 1'b0;
   endtask

   task automatic count_stall(output int n);
      n = 0;
      while (cpu_bus.cpu_enable !== 1'b1 && n < 50) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      int base;
      cpu_bus.req_rd = 1'b0; cpu_bus.req_wr = 1'b0; cpu_bus.req_size = 2'd0;
      cpu_bus.req_addr = '0; cpu_bus.req_wdata = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_enable", cpu_bus.cpu_enable, 1);
      chk("rst_data",   cpu_bus.data_out, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_addr",   mem_addr, 0);
      chk("rst_wdata",  mem_wdata, 0);
      chk("rst_err",    err_conflict, 0);
      rst = 1'b0;

      // 32-bit read
      bd_write(16'h0100, 8'h78);
      bd_write(16'h0101, 8'h56);
      bd_write(16'h0102, 8'h34);
      bd_write(16'h0103, 8'h12);
      do_req(1'b1, 1'b0, 2'd2, 32'h0000_0100, '0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rd32_addr%0d", k), mem_addr, 64'h100 + k);
         chk($sformatf("rd32_rd%0d", k), mem_rd, 1);
         chk($sformatf("rd32_stall%0d", k), cpu_bus.cpu_enable, 0);
         @(negedge clk);
      end
      chk("rd32_c5_stall", cpu_bus.cpu_enable, 0);
      chk("rd32_c5_rd",    mem_rd, 0);
      chk("rd32_c5_hold",  cpu_bus.data_out, 0);
      @(negedge clk);
      chk("rd32_c6_enable", cpu_bus.cpu_enable, 1);
      chk("rd32_data",      cpu_bus.data_out, 64'h0000_1234_5678);

      // 48-bit write
      base = wr_strobes;
      do_req(1'b0, 1'b1, 2'd3, 32'h0000_0200, 48'hAABB_CCDD_EEFF);
      chk("wr48_c1_wr",    mem_wr, 1);
      chk("wr48_c1_wdata", mem_wdata, 8'hFF);
      count_stall(n);
      chk("wr48_stall", n, 6);
      chk("wr48_ram", {ram[16'h205], ram[16'h204], ram[16'h203],
                       ram[16'h202], ram[16'h201], ram[16'h200]}, 48'hAABB_CCDD_EEFF);
      chk("wr48_strobes", wr_strobes - base, 6);
      chk("wr48_data_held", cpu_bus.data_out, 64'h0000_1234_5678);

      // 16-bit read across the address wrap (upper CPU address bits dropped)
      bd_write(16'hFFFF, 8'h34);
      bd_write(16'h0000, 8'h12);
      do_req(1'b1, 1'b0, 2'd1, 32'h0001_FFFF, '0);
      chk("wrap_addr0", mem_addr, 16'hFFFF);
      @(negedge clk);
      chk("wrap_addr1", mem_addr, 16'h0000);
      @(negedge clk);
      count_stall(n);
      chk("wrap_drain", n, 1);
      chk("wrap_data", cpu_bus.data_out, 64'h1234);

      // read and write together: read wins, error latches
      bd_write(16'h0010, 8'h5A);
      base = wr_strobes;
      do_req(1'b1, 1'b1, 2'd0, 32'h0000_0010, 48'h99);
      count_stall(n);
      chk("conf_stall", n, 2);
      chk("conf_data", cpu_bus.data_out, 64'h5A);
      chk("conf_err", err_conflict, 1);
      chk("conf_no_wr", wr_strobes - base, 0);

      // write then read on the first idle cycle
      do_req(1'b0, 1'b1, 2'd0, 32'h0000_0300, 48'h77);
      chk("b2b_c1_stall", cpu_bus.cpu_enable, 0);
      chk("b2b_c1_wr", mem_wr, 1);
      cpu_bus.req_rd = 1'b1; cpu_bus.req_size = 2'd0; cpu_bus.req_addr = 32'h0000_0300;
      @(negedge clk);
      chk("b2b_idle", cpu_bus.cpu_enable, 1);
      @(negedge clk);
      cpu_bus.req_rd = 1'b0;
      count_stall(n);
      chk("b2b_low_total", 1 + n, 3);
      chk("b2b_data", cpu_bus.data_out, 64'h77);
      chk("b2b_err_sticky", err_conflict, 1);

      // reset in the middle of a 48-bit read
      do_req(1'b1, 1'b0, 2'd3, 32'h0000_0400, '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_rd", mem_rd, 0);
      chk("rstmid_enable", cpu_bus.cpu_enable, 1);
      chk("rstmid_data", cpu_bus.data_out, 0);
      chk("rstmid_err", err_conflict, 0);
      rst = 1'b0;
      base = rd_strobes;
      repeat (10) @(negedge clk);
      chk("rstmid_no_strobes", rd_strobes - base, 0);
      chk("rstmid_idle", cpu_bus.cpu_enable, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
